// File: rtl/seq_multiplier.sv
// Shift-add sequential multiplier, one multiplier bit per clock.
// Define SEQ_MULT_SIGNED_EN for two's complement operands and product.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_mcand;
    logic [PW-1:0]   r_p;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]   r_cnt;
    logic            r_out_valid;

    logic            w_last;
    logic [PW-1:0]   w_ext_a;
    logic [PW-1:0]   w_step;
    logic [PW-1:0]   w_acc_nxt;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
    // The multiplier MSB carries weight -2^(W-1), so the last step subtracts.
    assign w_ext_a = {{WIDTH{a[WIDTH-1]}}, a};
    assign w_step  = w_last ? (r_acc - r_mcand) : (r_acc + r_mcand);
`else
    assign w_ext_a = {{WIDTH{1'b0}}, a};
    assign w_step  = r_acc + r_mcand;
`endif

    assign w_acc_nxt = r_mplier[0] ? w_step : r_acc;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign p         = r_p;

    // Handshake FSM and shift-add datapath; p only moves on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_p         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= w_ext_a;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_p         <= w_acc_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule
